fx_eval_mc: RTL and testbench
=============================

Name: fx_eval_mc

Overview:
- Parametrised, multicycle Nios II custom-instruction evaluator for y = HALF*x + x^2 * cos((x - OFFSET) * SCALE) + s.
- Built from the team's fp_multiplier, fp_adder, fp_subtractor and CORDIC cores.
- Adds latency-balanced operand alignment, a start/done handshake, and an internal accumulator selected by the opcode input n.
- Sits on the CPU custom-instruction port in place of the current single-shot evaluator.

Parameters:
- MULT_LAT, 5, fp_multiplier pipeline latency in cycles.
- ADD_LAT, 7, fp_adder latency; fp_subtractor has the same latency.
- CORDIC_LAT, 16, CORDIC cosine latency.
- C_OFFSET, 32'h43000000, IEEE-754 single offset subtracted from x (128.0).
- C_SCALE, 32'h3C000000, single-precision scale applied after subtraction (1/128).
- C_HALF, 32'h3F000000, linear coefficient (0.5).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- clk_en  in  1  global stall; when 0, every register and counter in the block holds.
- start  in  1  one-cycle command strobe.
- n  in  2  opcode: 0 EVAL, 1 EVAL_ACC, 2 READ_ACC, 3 CLR_ACC.
- dataa  in  32  x, single precision.
- datab  in  32  s, single precision; used only when n=0.
- done  out  1  one-cycle completion pulse.
- result  out  32  single-precision result; valid while done=1 and held until the next done.

Behaviour:
- One clock. Reset is synchronous and active-low. Port names are clk and rst_n.
- Reset (rst_n=0 at an edge): done=0, result=0, acc=0, state=IDLE, cycle counter=0. The FP core aclr inputs are tied 0; stale core contents are masked by the state machine.
- LAT_TOTAL = ADD_LAT + MULT_LAT + CORDIC_LAT + MULT_LAT + ADD_LAT. With the defaults this is 40.
- Datapath:
  - t = (x - C_OFFSET) * C_SCALE, then c = cos(t).
  - q = x*x, delayed so it meets c.
  - p = C_HALF*x + s', delayed so it meets c*q.
  - y = c*q + p.
  - s' = datab for EVAL; s' = acc for EVAL_ACC.
- Delay lines are shift registers gated by clk_en:
  - q delay depth = ADD_LAT + CORDIC_LAT.
  - p delay depth = ADD_LAT + MULT_LAT + CORDIC_LAT + MULT_LAT - (MULT_LAT + ADD_LAT).
- dataa, datab and n are registered at start. Inputs are don't-care at all other times.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 with clk_en=1 and n in {0,1} -> RUN, counter loaded with LAT_TOTAL-1.
  - IDLE: start=1 with clk_en=1 and n in {2,3} -> DONE.
  - IDLE: start with clk_en=0 is ignored.
  - RUN: counter decrements once per clk_en=1 cycle. When the counter reaches 0 -> DONE, capturing y.
  - DONE: done=1 for exactly one cycle, then -> IDLE. In DONE with clk_en=0, state and done hold; done stays high until the first clk_en=1 edge.
- Latency, counted in clk_en=1 cycles after the start edge:
  - EVAL and EVAL_ACC: done rises LAT_TOTAL+1 cycles after start.
  - READ_ACC and CLR_ACC: done rises 1 cycle after start.
- Results per opcode:
  - EVAL: result=y; acc unchanged.
  - EVAL_ACC: result=y and acc<=y, both written in the same edge as entry to DONE.
  - READ_ACC: result=acc.
  - CLR_ACC: acc<=0 and result=0.
- start while in RUN or DONE is ignored: no queuing, no effect on the operation in flight.
- rst_n=0 during RUN aborts the operation. No done is issued for it and acc is cleared.
- IEEE special values (inf, NaN, denormal flush) follow the FP cores unchanged. acc may become inf and is cleared only by CLR_ACC or reset.

Test Plan:
1. Reset, then EVAL with dataa=32'h43000000 (128.0), datab=0 -> done exactly 41 cycles after start, result=32'h46808000 (16448.0).
2. EVAL with dataa=0, datab=32'h3F800000 -> result=32'h3F800000.
3. CLR_ACC -> done after 1 cycle, result=0. Then EVAL_ACC twice with x=128.0 -> results 32'h46808000 then 32'h47008000; READ_ACC -> 32'h47008000.
4. Repeat case 1 with clk_en=0 for 3 cycles mid-RUN -> done arrives 44 cycles after start, result identical.
5. start pulses at cycles 5 and 20 of a RUN -> exactly one done; result and acc unaffected by the extra pulses.
6. rst_n=0 for 1 cycle mid-EVAL_ACC -> no done pulse, READ_ACC afterwards returns 0. A new EVAL then completes normally.

Source files
------------

// File: rtl/fx_eval_mc.sv
// Multicycle custom-instruction evaluator: y = HALF*x + x^2*cos((x-OFFSET)*SCALE) + s,
// with a start/done handshake and an opcode-selected accumulator.

module fx_dly #(
  parameter int W = 32,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (D == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [D-1:0][W-1:0] sr_q;
      always_ff @(posedge clk)
        if (en) begin
          sr_q[0] <= d;
          for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
        end
      assign q = sr_q[D-1];
    end
  endgenerate
endmodule

// Single-precision multiply: denormals flush to zero, mantissa truncated.
module fx_fp_mul #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]       r;
  logic [24:0]       ph;
  logic signed [9:0] e;
  logic              za, zb, ia, ib;

  always_comb begin
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = a[30:23] == 8'hFF;
    ib = b[30:23] == 8'hFF;
    ph = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
    e  = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(ph[24]);
    r  = {a[31] ^ b[31], e[7:0], ph[24] ? ph[23:1] : ph[22:0]};
    if ((ia && a[22:0] != 23'd0) || (ib && b[22:0] != 23'd0) || (ia && zb) || (ib && za))
      r = 32'h7FC0_0000;
    else if (ia || ib || e >= 10'sd255) r = {a[31] ^ b[31], 8'hFF, 23'd0};
    else if (za || zb || e <= 10'sd0)   r = {a[31] ^ b[31], 31'd0};
  end

  fx_dly #(.W(32), .D(LAT)) u_dly (.clk(clk), .en(clk_en), .d(r), .q(y));
endmodule

// Single-precision add (SUB=1 negates b): three guard bits, truncating, denormals flushed.
module fx_fp_add #(
  parameter int LAT = 7,
  parameter bit SUB = 1'b0
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]       r, bx, big, sml;
  logic [26:0]       mb, ms, msh;
  logic [27:0]       sum;
  logic [7:0]        d;
  logic [4:0]        pa;
  logic signed [9:0] e;

  always_comb begin
    bx  = {b[31] ^ SUB, b[30:0]};
    big = (bx[30:0] > a[30:0]) ? bx : a;
    sml = (bx[30:0] > a[30:0]) ? a : bx;
    mb  = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    ms  = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d   = big[30:23] - sml[30:23];
    msh = (d > 8'd26) ? 27'd0 : ms >> d;
    sum = (big[31] == sml[31]) ? {1'b0, mb} + {1'b0, msh} : {1'b0, mb} - {1'b0, msh};
    pa  = 5'd0;
    for (int i = 0; i < 28; i++) if (sum[i]) pa = 5'(i);
    e   = 10'(big[30:23]) + 10'(pa) - 10'd26;
    r   = {big[31], e[7:0],
           23'(((pa == 5'd27) ? (sum >> 1) : (sum << (5'd26 - pa))) >> 3)};
    if (big[30:23] == 8'hFF)
      r = (big[22:0] != 23'd0 || (sml[30:23] == 8'hFF && big[31] != sml[31])) ? 32'h7FC0_0000 : big;
    else if (sum == 28'd0 || e <= 10'sd0) r = 32'd0;
    else if (e >= 10'sd255)               r = {big[31], 8'hFF, 23'd0};
  end

  fx_dly #(.W(32), .D(LAT)) u_dly (.clk(clk), .en(clk_en), .d(r), .q(y));
endmodule

// Cosine: angle to Q3.29 (saturated at +/-4 rad), fold into +/-pi/2, 16-step rotation CORDIC,
// result rounded to 20 fractional bits so exact angles like 0 give exact floats.
module fx_cordic_cos #(
  parameter int LAT = 16
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic [31:0] t,
  output logic [31:0] y
);
  localparam logic signed [31:0] HALF_PI = 32'sd843314857;
  localparam logic signed [31:0] PI      = 32'sd1686629713;
  localparam logic signed [31:0] K_INV   = 32'sd652032875;
  localparam logic signed [31:0] ATAN [16] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384};

  logic [31:0]        r, mag, m;
  logic signed [31:0] z, xc, yc, dx, dy, xr;
  logic               neg;
  logic [4:0]         pm;

  always_comb begin
    if (t[30:23] >= 8'd129)      mag = 32'h7FFF_FFFF;
    else if (t[30:23] >= 8'd121) mag = {8'd0, 1'b1, t[22:0]} << (t[30:23] - 8'd121);
    else if (t[30:23] >= 8'd98)  mag = {8'd0, 1'b1, t[22:0]} >> (8'd121 - t[30:23]);
    else                         mag = 32'd0;
    z   = t[31] ? -$signed(mag) : $signed(mag);
    neg = 1'b0;
    if (z > HALF_PI)       begin z = z - PI; neg = 1'b1; end
    else if (z < -HALF_PI) begin z = z + PI; neg = 1'b1; end
    xc = K_INV;
    yc = 32'sd0;
    for (int i = 0; i < 16; i++) begin
      dx = yc >>> i;
      dy = xc >>> i;
      if (z >= 0) begin xc = xc - dx; yc = yc + dy; z = z - ATAN[i]; end
      else        begin xc = xc + dx; yc = yc - dy; z = z + ATAN[i]; end
    end
    xr = (xc + 32'sd512) >>> 10;
    if (neg) xr = -xr;
    m  = xr[31] ? 32'(-xr) : 32'(xr);
    pm = 5'd0;
    for (int i = 0; i < 32; i++) if (m[i]) pm = 5'(i);
    r = (m == 32'd0) ? 32'd0 : {xr[31], 8'(8'd107 + {3'd0, pm}), 23'(m << (5'd23 - pm))};
  end

  fx_dly #(.W(32), .D(LAT)) u_dly (.clk(clk), .en(clk_en), .d(r), .q(y));
endmodule

module fx_eval_mc #(
  parameter int          MULT_LAT   = 5,
  parameter int          ADD_LAT    = 7,
  parameter int          CORDIC_LAT = 16,
  parameter logic [31:0] C_OFFSET   = 32'h4300_0000,
  parameter logic [31:0] C_SCALE    = 32'h3C00_0000,
  parameter logic [31:0] C_HALF     = 32'h3F00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);
  localparam int LAT_TOTAL = ADD_LAT + MULT_LAT + CORDIC_LAT + MULT_LAT + ADD_LAT;
  localparam int Q_DLY     = ADD_LAT + CORDIC_LAT;
  localparam int P_DLY     = ADD_LAT + MULT_LAT + CORDIC_LAT + MULT_LAT - (MULT_LAT + ADD_LAT);
  localparam int CW        = $clog2(LAT_TOTAL);
  localparam logic [1:0] OP_ACC = 2'd1, OP_READ = 2'd2, OP_CLR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] x_q, s_q, acc_q, acc_d, res_q, res_d;
  logic [1:0]  n_q, n_op;
  logic        idle;
  logic [31:0] x_op, s_op, xo, t, c, q0, q, cq, hx, p0, p, y;

  // The start edge already feeds the pipelines straight from the ports, so y is
  // valid exactly LAT_TOTAL enabled edges later; operands then stay frozen for the run.
  assign idle = state_q == S_IDLE;
  assign x_op = idle ? dataa : x_q;
  assign n_op = idle ? n : n_q;
  assign s_op = (n_op == OP_ACC) ? acc_q : (idle ? datab : s_q);

  fx_fp_add #(.LAT(ADD_LAT), .SUB(1'b1)) u_sub (.clk(clk), .clk_en(clk_en), .a(x_op), .b(C_OFFSET), .y(xo));
  fx_fp_mul #(.LAT(MULT_LAT)) u_scl (.clk(clk), .clk_en(clk_en), .a(xo), .b(C_SCALE), .y(t));
  fx_cordic_cos #(.LAT(CORDIC_LAT)) u_cos (.clk(clk), .clk_en(clk_en), .t(t), .y(c));
  fx_fp_mul #(.LAT(MULT_LAT)) u_sq (.clk(clk), .clk_en(clk_en), .a(x_op), .b(x_op), .y(q0));
  fx_dly #(.W(32), .D(Q_DLY)) u_qd (.clk(clk), .en(clk_en), .d(q0), .q(q));
  fx_fp_mul #(.LAT(MULT_LAT)) u_cq (.clk(clk), .clk_en(clk_en), .a(c), .b(q), .y(cq));
  fx_fp_mul #(.LAT(MULT_LAT)) u_hx (.clk(clk), .clk_en(clk_en), .a(C_HALF), .b(x_op), .y(hx));
  fx_fp_add #(.LAT(ADD_LAT), .SUB(1'b0)) u_p (.clk(clk), .clk_en(clk_en), .a(hx), .b(s_op), .y(p0));
  fx_dly #(.W(32), .D(P_DLY)) u_pd (.clk(clk), .en(clk_en), .d(p0), .q(p));
  fx_fp_add #(.LAT(ADD_LAT), .SUB(1'b0)) u_y (.clk(clk), .clk_en(clk_en), .a(cq), .b(p), .y(y));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE:
        if (start) begin
          if (!n[1]) begin
            state_d = S_RUN;
            cnt_d   = CW'(LAT_TOTAL - 1);
          end else begin
            state_d = S_DONE;
            res_d   = (n == OP_READ) ? acc_q : 32'd0;
            if (n == OP_CLR) acc_d = 32'd0;
          end
        end
      S_RUN:
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = y;
          if (n_q == OP_ACC) acc_d = y;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      x_q     <= '0;
      s_q     <= '0;
      n_q     <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      if (idle && start) begin
        x_q <= dataa;
        s_q <= datab;
        n_q <= n;
      end
    end

  assign done   = state_q == S_DONE;
  assign result = res_q;
endmodule

// File: tb/tb_fx_eval_mc.sv
// Directed bench for fx_eval_mc: latency, results, accumulator, stall, ignored starts, abort.

module tb_fx_eval_mc;
  logic        clk, rst_n, clk_en, start, done;
  logic [1:0]  n;
  logic [31:0] dataa, datab, result;
  int          n_chk = 0, n_err = 0;
  int          cyc;
  logic [31:0] res;
  logic        got;

  fx_eval_mc dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issues one command; cyc counts edges from the start edge (inclusive) to done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int st_at, input int st_len, input int pa, input int pb,
                        input int rst_at, input int maxc,
                        output int c, output logic [31:0] r, output logic g);
    @(negedge clk);
    start = 1'b1; n = op; dataa = a; datab = b;
    c = 0; g = 1'b0; r = '0;
    while (!g && c < maxc) begin
      @(negedge clk);
      c++;
      n = 2'd3; dataa = 32'hDEAD_BEEF; datab = 32'h1234_5678;
      if (done) begin
        g = 1'b1;
        r = result;
      end else begin
        clk_en = !(c >= st_at && c < st_at + st_len);
        start  = (c == pa) || (c == pb);
        rst_n  = (c != rst_at);
      end
    end
    start = 1'b0; clk_en = 1'b1; rst_n = 1'b1;
    if (g) begin
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic op_chk(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int st_at, input int st_len, input int pa, input int pb);
    int          c;
    logic [31:0] r;
    logic        g;
    run_op(op, a, b, st_at, st_len, pa, pb, -1, 80, c, r, g);
    chk({tag, "_lat"}, 32'(c), 32'(exp_lat));
    chk({tag, "_res"}, r, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = '0; datab = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);

    op_chk("eval128",  2'd0, 32'h4300_0000, 32'h0000_0000, 32'h4680_8000, 41, -1, 0, -1, -1);
    op_chk("read0",    2'd2, 32'h0,         32'h0,         32'h0000_0000,  1, -1, 0, -1, -1);
    op_chk("eval0",    2'd0, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 41, -1, 0, -1, -1);
    op_chk("clr",      2'd3, 32'h0,         32'h0,         32'h0000_0000,  1, -1, 0, -1, -1);
    op_chk("acc1",     2'd1, 32'h4300_0000, 32'h7F80_0000, 32'h4680_8000, 41, -1, 0, -1, -1);
    op_chk("acc2",     2'd1, 32'h4300_0000, 32'h0000_0000, 32'h4700_8000, 41, -1, 0, -1, -1);
    op_chk("read1",    2'd2, 32'h0,         32'h0,         32'h4700_8000,  1, -1, 0, -1, -1);
    op_chk("stall",    2'd0, 32'h4300_0000, 32'h0000_0000, 32'h4680_8000, 44, 10, 3, -1, -1);
    op_chk("pulses",   2'd0, 32'h4300_0000, 32'h0000_0000, 32'h4680_8000, 41, -1, 0,  5, 20);
    op_chk("read2",    2'd2, 32'h0,         32'h0,         32'h4700_8000,  1, -1, 0, -1, -1);

    run_op(2'd1, 32'h4300_0000, 32'h0, -1, 0, -1, -1, 10, 60, cyc, res, got);
    chk("abort_no_done", {31'd0, got}, 32'd0);
    op_chk("read_abort", 2'd2, 32'h0,       32'h0,         32'h0000_0000,  1, -1, 0, -1, -1);
    op_chk("eval_after", 2'd0, 32'h4300_0000, 32'h0,       32'h4680_8000, 41, -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
